// File: rtl/modexp_engine.sv
// Modular exponentiation engine: result = base^exp mod modulus, with right-to-left or
// left-to-right binary scanning, built around one shared bit-serial interleaved multiplier.
module modexp_engine #(
   parameter int WIDTH     = 32,
   parameter int EXP_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start,
   input  logic                 mode,
   input  logic [WIDTH-1:0]     base,
   input  logic [EXP_WIDTH-1:0] exp,
   input  logic [WIDTH-1:0]     modulus,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     result,
   output logic                 err
);
   localparam int LW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
   localparam int SW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REDUCE, S_LOOP, S_FIN} state_t;

   state_t               state;
   logic                 mode_q, ph_q, err_q;
   logic [WIDTH-1:0]     base_q, mod_q, r_q, b_q;
   logic [EXP_WIDTH-1:0] exp_q;
   logic [LW-1:0]        hi_q, j_q, msb, j_inc, nxt_j;
   logic                 nxt_ph, last_op;
   logic [WIDTH-1:0]     ma, mb, mr, op_a, op_b, mul_next;
   logic [SW-1:0]        step;
   logic [WIDTH:0]       dbl, dbl_red, acc, acc_red;

   always_comb begin
      msb = '0;
      for (int i = 0; i < EXP_WIDTH; i++)
         if (exp_q[i]) msb = LW'(i);
   end

   // One multiplier step on WIDTH+1 bits: both partial sums stay below 2N.
   always_comb begin
      dbl      = {mr, 1'b0};
      dbl_red  = (dbl >= {1'b0, mod_q}) ? dbl - {1'b0, mod_q} : dbl;
      acc      = dbl_red + (ma[WIDTH-1] ? {1'b0, mb} : '0);
      acc_red  = (acc >= {1'b0, mod_q}) ? acc - {1'b0, mod_q} : acc;
      mul_next = acc_red[WIDTH-1:0];
   end

   assign j_inc = j_q + 1'b1;

   // Operand selection for the next multiply and the position of the following one.
   always_comb begin
      op_a    = r_q;
      op_b    = b_q;
      nxt_j   = j_q;
      nxt_ph  = 1'b0;
      last_op = 1'b0;
      if (state == S_REDUCE) begin
         op_a = base_q;
         op_b = WIDTH'(1);
         if (!mode_q) begin
            nxt_j  = '0;
            nxt_ph = ~exp_q[0];
         end else begin
            nxt_j   = hi_q - 1'b1;
            last_op = (hi_q == '0);
         end
      end else if (!mode_q) begin
         if (ph_q) begin
            op_a   = b_q;
            nxt_j  = j_inc;
            nxt_ph = ~exp_q[j_inc];
         end else begin
            nxt_ph  = 1'b1;
            last_op = (j_q == hi_q);
         end
      end else begin
         if (ph_q) begin
            nxt_j   = j_q - 1'b1;
            last_op = (j_q == '0);
         end else begin
            op_b = r_q;
            if (exp_q[j_q]) begin
               nxt_ph = 1'b1;
            end else begin
               nxt_j   = j_q - 1'b1;
               last_op = (j_q == '0);
            end
         end
      end
   end

   // NOTE: every register here is assigned with <= so all state updates see pre-edge values.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         state  <= S_IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         err    <= 1'b0;
         mode_q <= 1'b0;
         ph_q   <= 1'b0;
         err_q  <= 1'b0;
         base_q <= '0;
         mod_q  <= '0;
         exp_q  <= '0;
         r_q    <= '0;
         b_q    <= '0;
         hi_q   <= '0;
         j_q    <= '0;
         ma     <= '0;
         mb     <= '0;
         mr     <= '0;
         step   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && !done) begin
                  mode_q <= mode;
                  base_q <= base;
                  exp_q  <= exp;
                  mod_q  <= modulus;
                  busy   <= 1'b1;
                  state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               hi_q  <= msb;
               step  <= '0;
               err_q <= 1'b0;
               if (mod_q == '0) begin
                  r_q   <= '0;
                  err_q <= 1'b1;
                  state <= S_FIN;
               end else if (mod_q == WIDTH'(1)) begin
                  r_q   <= '0;
                  state <= S_FIN;
               end else if (exp_q == '0) begin
                  r_q   <= WIDTH'(1);
                  state <= S_FIN;
               end else begin
                  state <= S_REDUCE;
               end
            end
            S_REDUCE, S_LOOP: begin
               if (step == '0) begin
                  ma   <= op_a;
                  mb   <= op_b;
                  mr   <= '0;
                  step <= SW'(1);
               end else begin
                  mr <= mul_next;
                  ma <= {ma[WIDTH-2:0], 1'b0};
                  if (step == SW'(WIDTH)) begin
                     step <= '0;
                     if (state == S_REDUCE) begin
                        b_q <= mul_next;
                        r_q <= mode_q ? mul_next : WIDTH'(1);
                     end else if (!mode_q && ph_q) begin
                        b_q <= mul_next;
                     end else begin
                        r_q <= mul_next;
                     end
                     j_q   <= nxt_j;
                     ph_q  <= nxt_ph;
                     state <= last_op ? S_FIN : S_LOOP;
                  end else begin
                     step <= step + 1'b1;
                  end
               end
            end
            S_FIN: begin
               result <= r_q;
               err    <= err_q;
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_modexp_engine.sv
// Directed and randomised bench for modexp_engine at 32-bit and 64-bit operand widths.
module tb_modexp_engine;
   localparam int LIMIT = 5000;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rstn;

   logic        start32, mode32, busy32, done32, err32;
   logic [31:0] base32, exp32, mod32, result32;
   logic        start64, mode64, busy64, done64, err64;
   logic [63:0] base64, exp64, mod64, result64;

   int vectors = 0;
   int miscompares = 0;

   modexp_engine #(.WIDTH(32), .EXP_WIDTH(32)) dut32 (
      .clk(clk), .rstn(rstn), .start(start32), .mode(mode32), .base(base32), .exp(exp32),
      .modulus(mod32), .busy(busy32), .done(done32), .result(result32), .err(err32));

   modexp_engine #(.WIDTH(64), .EXP_WIDTH(64)) dut64 (
      .clk(clk), .rstn(rstn), .start(start64), .mode(mode64), .base(base64), .exp(exp64),
      .modulus(mod64), .busy(busy64), .done(done64), .result(result64), .err(err64));

   typedef struct {
      string       name;
      logic        m;
      logic [63:0] b, e, n, r;
      logic        er;
      int          lat;
   } vec_t;

   function automatic logic [31:0] ref_modexp(input logic [31:0] b, e, n);
      logic [63:0] r, x;
      if (n == 0) return 32'd0;
      r = 64'd1 % n;
      x = b % n;
      for (int i = 0; i < 32; i++) begin
         if (e[i]) r = (r * x) % n;
         x = (x * x) % n;
      end
      return r[31:0];
   endfunction

   function automatic int ref_lat(input logic m, input logic [31:0] e, n);
      int l, ops;
      if (n < 2 || e == 0) return 2;
      l = 0;
      for (int i = 0; i < 32; i++) if (e[i]) l = i;
      ops = m ? l + $countones(e) - 1 : l + $countones(e);
      return 2 + (1 + ops) * 33;
   endfunction

   // Issue one operation (waiting out a done cycle first) and count cycles to done.
   task automatic do_op32(input logic m, input logic [31:0] b, e, n, input int pulse_at,
                          output logic [31:0] res, output logic er, output int lat);
      @(negedge clk);
      if (done32) @(negedge clk);
      mode32 = m; base32 = b; exp32 = e; mod32 = n; start32 = 1'b1;
      @(posedge clk);
      #1;
      start32 = 1'b0;
      lat = 0;
      while (!done32 && lat < LIMIT) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == pulse_at) begin
            start32 = 1'b1; mode32 = ~m; base32 = 32'd10; exp32 = 32'd3; mod32 = 32'd7;
         end else if (lat == pulse_at + 1) begin
            start32 = 1'b0;
         end
      end
      res = result32;
      er  = err32;
   endtask

   task automatic do_op64(input logic m, input logic [63:0] b, e, n,
                          output logic [63:0] res, output logic er, output int lat);
      @(negedge clk);
      if (done64) @(negedge clk);
      mode64 = m; base64 = b; exp64 = e; mod64 = n; start64 = 1'b1;
      @(posedge clk);
      #1;
      start64 = 1'b0;
      lat = 0;
      while (!done64 && lat < LIMIT) begin
         @(posedge clk);
         #1;
         lat++;
      end
      res = result64;
      er  = err64;
   endtask

   task automatic test_reset;
      rstn = 1'b1;
      start32 = 0; mode32 = 0; base32 = 0; exp32 = 0; mod32 = 0;
      start64 = 0; mode64 = 0; base64 = 0; exp64 = 0; mod64 = 0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({busy32, done32, err32, result32} !== 35'd0) begin
         miscompares++;
         $display("FAIL reset32 outputs got %h want 0", {busy32, done32, err32, result32});
      end
      vectors++;
      if ({busy64, done64, err64, result64} !== 67'd0) begin
         miscompares++;
         $display("FAIL reset64 outputs got %h want 0", {busy64, done64, err64, result64});
      end
      @(negedge clk);
      rstn = 1'b0;
   endtask

   task automatic test_directed32;
      vec_t        tbl [11];
      logic [31:0] res;
      logic        er;
      int          lat;
      tbl[0]  = '{"rtl_4_13_497", 1'b0, 64'd4, 64'd13, 64'd497, 64'd445, 1'b0, 233};
      tbl[1]  = '{"ltr_4_13_497", 1'b1, 64'd4, 64'd13, 64'd497, 64'd445, 1'b0, 200};
      tbl[2]  = '{"rtl_prereduce", 1'b0, 64'd10, 64'd3, 64'd7, 64'd6, 1'b0, 134};
      tbl[3]  = '{"ltr_prereduce", 1'b1, 64'd10, 64'd3, 64'd7, 64'd6, 1'b0, 101};
      tbl[4]  = '{"exp_zero", 1'b0, 64'd3, 64'd0, 64'd7, 64'd1, 1'b0, 2};
      tbl[5]  = '{"mod_zero", 1'b0, 64'd5, 64'd3, 64'd0, 64'd0, 1'b1, 2};
      tbl[6]  = '{"mod_one", 1'b1, 64'd5, 64'd3, 64'd1, 64'd0, 1'b0, 2};
      tbl[7]  = '{"rtl_exp_one", 1'b0, 64'd10, 64'd1, 64'd7, 64'd3, 1'b0, 68};
      tbl[8]  = '{"ltr_exp_one", 1'b1, 64'd10, 64'd1, 64'd7, 64'd3, 1'b0, 35};
      tbl[9]  = '{"rtl_exp_msb", 1'b0, 64'd3, 64'h8000_0000, 64'd7, 64'd2, 1'b0, 1091};
      tbl[10] = '{"ltr_exp_msb", 1'b1, 64'd3, 64'h8000_0000, 64'd7, 64'd2, 1'b0, 1058};
      foreach (tbl[k]) begin
         do_op32(tbl[k].m, tbl[k].b[31:0], tbl[k].e[31:0], tbl[k].n[31:0], 0, res, er, lat);
         vectors++;
         if (res !== tbl[k].r[31:0]) begin
            miscompares++;
            $display("FAIL %s result got %0d want %0d", tbl[k].name, res, tbl[k].r);
         end
         vectors++;
         if (er !== tbl[k].er) begin
            miscompares++;
            $display("FAIL %s err got %b want %b", tbl[k].name, er, tbl[k].er);
         end
         vectors++;
         if (lat !== tbl[k].lat) begin
            miscompares++;
            $display("FAIL %s latency got %0d want %0d", tbl[k].name, lat, tbl[k].lat);
         end
         vectors++;
         if (busy32 !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_at_done got %b want 0", tbl[k].name, busy32);
         end
      end
      @(posedge clk);
      #1;
      vectors++;
      if (done32 !== 1'b0) begin
         miscompares++;
         $display("FAIL done_one_cycle got %b want 0", done32);
      end
   endtask

   task automatic test_wide64;
      vec_t        tbl [4];
      logic [63:0] res;
      logic        er;
      int          lat;
      tbl[0] = '{"w64_rtl_big", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFC5,
                 64'd3364, 1'b0, 197};
      tbl[1] = '{"w64_ltr_big", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFC5,
                 64'd3364, 1'b0, 132};
      tbl[2] = '{"w64_rtl_2_10", 1'b0, 64'd2, 64'd10, 64'd1000, 64'd24, 1'b0, 392};
      tbl[3] = '{"w64_ltr_2_10", 1'b1, 64'd2, 64'd10, 64'd1000, 64'd24, 1'b0, 327};
      foreach (tbl[k]) begin
         do_op64(tbl[k].m, tbl[k].b, tbl[k].e, tbl[k].n, res, er, lat);
         vectors++;
         if (res !== tbl[k].r || er !== tbl[k].er) begin
            miscompares++;
            $display("FAIL %s result/err got %0d/%b want %0d/%b", tbl[k].name, res, er,
                     tbl[k].r, tbl[k].er);
         end
         vectors++;
         if (lat !== tbl[k].lat) begin
            miscompares++;
            $display("FAIL %s latency got %0d want %0d", tbl[k].name, lat, tbl[k].lat);
         end
      end
   endtask

   task automatic test_start_while_busy;
      logic [31:0] res;
      logic        er;
      int          lat;
      do_op32(1'b0, 32'd4, 32'd13, 32'd497, 50, res, er, lat);
      vectors++;
      if (res !== 32'd445 || lat !== 233) begin
         miscompares++;
         $display("FAIL busy_start_ignored result/lat got %0d/%0d want 445/233", res, lat);
      end
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (busy32 !== 1'b0) begin
         miscompares++;
         $display("FAIL busy_start_not_queued busy got %b want 0", busy32);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] res;
      logic        er;
      int          lat;
      do_op32(1'b0, 32'd4, 32'd13, 32'd497, 0, res, er, lat);
      mode32 = 1'b1; base32 = 32'd10; exp32 = 32'd3; mod32 = 32'd7; start32 = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (busy32 !== 1'b0) begin
         miscompares++;
         $display("FAIL start_in_done_cycle busy got %b want 0", busy32);
      end
      @(posedge clk);
      #1;
      start32 = 1'b0;
      vectors++;
      if (busy32 !== 1'b1) begin
         miscompares++;
         $display("FAIL start_after_done busy got %b want 1", busy32);
      end
      lat = 0;
      while (!done32 && lat < LIMIT) begin
         @(posedge clk);
         #1;
         lat++;
      end
      vectors++;
      if (result32 !== 32'd6 || lat !== 101) begin
         miscompares++;
         $display("FAIL back_to_back result/lat got %0d/%0d want 6/101", result32, lat);
      end
   endtask

   task automatic test_random;
      logic [31:0] b, e, n, res;
      logic        m, er;
      int          lat;
      for (int k = 0; k < 8; k++) begin
         m = 1'($urandom_range(0, 1));
         b = $urandom;
         e = $urandom_range(0, 65535);
         n = (k == 0) ? 32'hFFFF_FFFF : $urandom;
         do_op32(m, b, e, n, 0, res, er, lat);
         vectors++;
         if (res !== ref_modexp(b, e, n) || er !== (n == 0)) begin
            miscompares++;
            $display("FAIL random%0d %0d^%0d mod %0d got %0d want %0d", k, b, e, n, res,
                     ref_modexp(b, e, n));
         end
         vectors++;
         if (lat !== ref_lat(m, e, n)) begin
            miscompares++;
            $display("FAIL random%0d latency got %0d want %0d", k, lat, ref_lat(m, e, n));
         end
      end
   endtask

   task automatic test_reset_midop;
      logic [31:0] res;
      logic        er;
      int          lat;
      int          seen;
      @(negedge clk);
      mode32 = 1'b0; base32 = 32'd4; exp32 = 32'd13; mod32 = 32'd497; start32 = 1'b1;
      @(posedge clk);
      #1;
      start32 = 1'b0;
      repeat (120) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      vectors++;
      if ({busy32, done32, err32, result32} !== 35'd0) begin
         miscompares++;
         $display("FAIL reset_midop outputs got %h want 0", {busy32, done32, err32, result32});
      end
      @(negedge clk);
      rstn = 1'b0;
      seen = 0;
      for (int c = 0; c < 300; c++) begin
         @(posedge clk);
         #1;
         if (done32 || busy32) seen++;
      end
      vectors++;
      if (seen !== 0) begin
         miscompares++;
         $display("FAIL reset_discard activity cycles got %0d want 0", seen);
      end
      do_op32(1'b1, 32'd4, 32'd13, 32'd497, 0, res, er, lat);
      vectors++;
      if (res !== 32'd445 || lat !== 200) begin
         miscompares++;
         $display("FAIL after_reset result/lat got %0d/%0d want 445/200", res, lat);
      end
   endtask

   initial begin
      test_reset();
      test_directed32();
      test_wide64();
      test_start_while_busy();
      test_back_to_back();
      test_random();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
